// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: per-channel enables and ratios in, divided clocks, ticks and pending flags out.
interface clk_div_multi_if #(
  parameter int NCH = 3,
  parameter int CW  = 8
);
  logic [NCH-1:0]    i_en;
  logic [NCH*CW-1:0] i_div;
  logic              i_load;
  logic              i_sync;
  logic [NCH-1:0]    o_clk_out;
  logic [NCH-1:0]    o_tick;
  logic [NCH-1:0]    o_pend;
  modport master (output i_en, i_div, i_load, i_sync, input o_clk_out, o_tick, o_pend);
  modport slave  (input i_en, i_div, i_load, i_sync, output o_clk_out, o_tick, o_pend);
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: NCH independent programmable dividers with shadowed ratio reload and phase-align restart.
module clk_div_multi #(
  parameter int NCH     = 3,
  parameter int CW      = 8,
  parameter int DEF_DIV = 10
) (
  input logic             i_clk,
  input logic             i_rst_n,
  clk_div_multi_if.slave  bus
);
  logic [CW-1:0]  r_cnt [NCH];
  logic [CW-1:0]  r_r   [NCH];
  logic [CW-1:0]  r_s   [NCH];
  logic [NCH-1:0] r_pend, r_clk, r_tick;
  logic [CW:0]    w_h   [NCH];
  logic [CW:0]    w_nxt [NCH];
  logic [CW-1:0]  w_div [NCH];
  logic [NCH-1:0] w_restart;
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_h[i]       = ({1'b0, r_r[i]} + (CW+1)'(1)) >> 1;
      w_nxt[i]     = {1'b0, r_cnt[i]} + (CW+1)'(1);
      w_div[i]     = bus.i_div[i*CW +: CW] < CW'(2) ? CW'(2) : bus.i_div[i*CW +: CW];
      w_restart[i] = bus.i_sync | (bus.i_en[i] & (r_cnt[i] == r_r[i] - CW'(1)));
    end
  end
  // Ratio swap happens only on a restart, so every period is timed by one R.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= CW'(DEF_DIV - 1);
        r_r[i]   <= CW'(DEF_DIV);
        r_s[i]   <= CW'(DEF_DIV);
      end
      r_pend <= '0;
      r_clk  <= '0;
      r_tick <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_restart[i]) begin
          r_cnt[i]  <= '0;
          r_clk[i]  <= 1'b1;
          r_tick[i] <= 1'b1;
          if (r_pend[i]) r_r[i] <= r_s[i];
        end else begin
          if (bus.i_en[i]) begin
            r_cnt[i] <= w_nxt[i][CW-1:0];
            r_clk[i] <= w_nxt[i] < w_h[i];
          end
          r_tick[i] <= 1'b0;
        end
        if (bus.i_load) begin
          r_s[i]    <= w_div[i];
          r_pend[i] <= 1'b1;
        end else if (w_restart[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end
  assign bus.o_clk_out = r_clk;
  assign bus.o_tick    = r_tick;
  assign bus.o_pend    = r_pend;
endmodule
